instr_queue: RTL
================

INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 Parameter DEPTH, default 32, number of instruction entries; power of two, >= 2.
REQ-002 Parameter OP_WIDTH, default 32, operand width in bits; result width RES_WIDTH = 2*OP_WIDTH.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 load_valid  input  1  producer offers an instruction this cycle.
REQ-006 load_ready  output  1  block accepts an instruction this cycle.
REQ-007 opcode  input  opcode_t (3)  ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD.
REQ-008 operand_a, operand_b  input  OP_WIDTH each  unsigned operands.
REQ-009 rd_en  input  1  read request.
REQ-010 rd_mode  input  1  0 = FIFO pop, 1 = random access, no pop.
REQ-011 read_pointer  input  log2(DEPTH)  entry index for random access.
REQ-012 out_valid  output  1  instruction_word valid this cycle.
REQ-013 instruction_word  output  {opcode, operand_a, operand_b, result (RES_WIDTH), err (1)}  read data.
REQ-014 count  output  log2(DEPTH)+1  committed entries.
REQ-015 full, empty  output  1 each  status flags.
REQ-016 underflow  output  1  one-cycle pulse on pop while empty.

Function
REQ-017 Accept occurs when load_valid && load_ready at a rising edge; inputs are captured into a one-entry compute stage.
REQ-018 Compute stage writes {opcode, a, b, result, err} into the entry at wr_ptr on the next edge; wr_ptr increments modulo DEPTH; committed count increments at that edge.
REQ-019 Accept-to-readable latency: 2 cycles (accept at edge N, entry committed at edge N+1, pop possible from edge N+2).
REQ-020 A reserved counter (committed + in-flight) increments on accept; load_ready = (reserved < DEPTH), independent of same-cycle pop.
REQ-021 Result rules, operands zero-extended to RES_WIDTH: ZERO -> 0; PASSA -> a; PASSB -> b; ADD -> a+b; SUB -> a-b modulo 2^RES_WIDTH; MULT -> full a*b; DIV -> a/b; MOD -> a%b.
REQ-022 DIV or MOD with b == 0: result 0, err = 1; err = 0 for all other cases.
REQ-023 FIFO pop (rd_en, rd_mode=0, committed != 0): instruction_word <= entry[rd_ptr], out_valid = 1 next cycle, rd_ptr increments modulo DEPTH, count and reserved decrement.
REQ-024 Pop while committed == 0: no state change, out_valid = 0, underflow = 1 next cycle.
REQ-025 Random access (rd_en, rd_mode=1): instruction_word <= entry[read_pointer], out_valid = 1 next cycle, no pointer or count change; stale or never-written entries return their stored contents.
REQ-026 Same-edge commit and pop: count unchanged, both pointers advance; the pop reads the previously committed head.
REQ-027 full = (count == DEPTH); empty = (count == 0); both derived from committed count.
REQ-028 Without rd_en, out_valid = 0 and instruction_word holds its last value.

Reset
REQ-029 On reset_n low, asynchronously: all entries, compute stage, instruction_word = {ZERO, 0, 0, 0, 0}; pointers, count, reserved = 0; out_valid, underflow = 0; empty = 1, full = 0.
REQ-030 Reset mid-operation discards the in-flight instruction; load_ready = 1 from the first edge after reset release.

Structure
REQ-031 Package instr_register_pkg holds opcode_t; width-dependent types are local to the module, derived from parameters.
REQ-032 Arithmetic sits in one combinational sub-module, instr_alu, parametrised by OP_WIDTH and driving result and err.

Verification (DEPTH=4, OP_WIDTH=32)
REQ-033 Load ADD a=5 b=7, pop at earliest cycle -> out_valid 2 cycles after accept, result 12, err 0.
REQ-034 Load DIV a=9 b=0, then MOD a=9 b=4, pop twice -> results 0/err 1, then 1/err 0.
REQ-035 Load four SUB a=0 b=1 -> full=1, load_ready=0, each result 2^64-1; fifth load_valid is not accepted.
REQ-036 Pop on empty after reset -> underflow pulse 1 cycle, out_valid 0, count 0.
REQ-037 Load MULT a=0xFFFFFFFF b=2, random-read index 0 twice -> result 0x1_FFFFFFFE both times, count stays 1.
REQ-038 Assert reset_n low in the cycle after an accept -> count 0, empty 1; pop after release -> underflow.

Source files
------------

// File: rtl/instr_register_pkg.sv
// Shared opcode encoding for the instruction queue and its ALU.
package instr_register_pkg;

  typedef enum logic [2:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

endpackage

// File: rtl/instr_queue_if.sv
// Load/read bus of the instruction queue; master = producer/consumer, slave = queue.
interface instr_queue_if
  import instr_register_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int OP_WIDTH = 32
);
  localparam int AW     = $clog2(DEPTH);
  localparam int WORD_W = 3 + 4 * OP_WIDTH + 1;

  logic                load_valid;
  logic                load_ready;
  opcode_t             opcode;
  logic [OP_WIDTH-1:0] operand_a;
  logic [OP_WIDTH-1:0] operand_b;
  logic                rd_en;
  logic                rd_mode;
  logic [AW-1:0]       read_pointer;
  logic                out_valid;
  logic [WORD_W-1:0]   instruction_word;
  logic [AW:0]         count;
  logic                full;
  logic                empty;
  logic                underflow;

  modport master (
    output load_valid, opcode, operand_a, operand_b, rd_en, rd_mode, read_pointer,
    input  load_ready, out_valid, instruction_word, count, full, empty, underflow
  );

  modport slave (
    input  load_valid, opcode, operand_a, operand_b, rd_en, rd_mode, read_pointer,
    output load_ready, out_valid, instruction_word, count, full, empty, underflow
  );

endinterface

// File: rtl/instr_alu.sv
// Combinational ALU: operands zero-extended to 2*OP_WIDTH; DIV/MOD by zero flag err.
module instr_alu
  import instr_register_pkg::*;
#(
  parameter int OP_WIDTH = 32
) (
  input  opcode_t               opcode,
  input  logic [OP_WIDTH-1:0]   operand_a,
  input  logic [OP_WIDTH-1:0]   operand_b,
  output logic [2*OP_WIDTH-1:0] result,
  output logic                  err
);
  localparam int RES_WIDTH = 2 * OP_WIDTH;

  logic [RES_WIDTH-1:0] a_ext;
  logic [RES_WIDTH-1:0] b_ext;

  assign a_ext = RES_WIDTH'(operand_a);
  assign b_ext = RES_WIDTH'(operand_b);

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (opcode)
      ZERO:  result = '0;
      PASSA: result = a_ext;
      PASSB: result = b_ext;
      ADD:   result = a_ext + b_ext;
      SUB:   result = a_ext - b_ext;
      MULT:  result = a_ext * b_ext;
      DIV: begin
        if (operand_b == '0) err = 1'b1;
        else                 result = a_ext / b_ext;
      end
      MOD: begin
        if (operand_b == '0) err = 1'b1;
        else                 result = a_ext % b_ext;
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/instr_queue.sv
// Instruction queue: one-entry compute stage feeding a DEPTH-entry FIFO that also
// supports random-access reads without popping.
module instr_queue
  import instr_register_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int OP_WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  instr_queue_if.slave  bus
);
  localparam int RES_WIDTH = 2 * OP_WIDTH;
  localparam int AW        = $clog2(DEPTH);

  typedef struct packed {
    opcode_t              opcode;
    logic [OP_WIDTH-1:0]  a;
    logic [OP_WIDTH-1:0]  b;
    logic [RES_WIDTH-1:0] result;
    logic                 err;
  } entry_t;

  entry_t               mem [DEPTH];
  entry_t               word_q;

  logic                 stage_valid;
  opcode_t              stage_op;
  logic [OP_WIDTH-1:0]  stage_a;
  logic [OP_WIDTH-1:0]  stage_b;
  logic [RES_WIDTH-1:0] alu_result;
  logic                 alu_err;

  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          committed;
  logic [AW:0]          reserved;

  logic                 accept;
  logic                 pop_req;
  logic                 pop;
  logic                 peek;

  // Ready looks only at reserved slots, so a same-cycle pop never frees space early.
  assign bus.load_ready = (reserved < (AW+1)'(DEPTH));
  assign accept         = bus.load_valid && bus.load_ready;
  assign pop_req        = bus.rd_en && !bus.rd_mode;
  assign pop            = pop_req && (committed != '0);
  assign peek           = bus.rd_en && bus.rd_mode;

  instr_alu #(.OP_WIDTH(OP_WIDTH)) u_alu (
    .opcode    (stage_op),
    .operand_a (stage_a),
    .operand_b (stage_b),
    .result    (alu_result),
    .err       (alu_err)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_valid <= 1'b0;
      stage_op    <= ZERO;
      stage_a     <= '0;
      stage_b     <= '0;
    end else begin
      stage_valid <= accept;
      if (accept) begin
        stage_op <= bus.opcode;
        stage_a  <= bus.operand_a;
        stage_b  <= bus.operand_b;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (stage_valid) begin
      mem[wr_ptr] <= '{opcode: stage_op, a: stage_a, b: stage_b,
                       result: alu_result, err: alu_err};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      committed <= '0;
      reserved  <= '0;
    end else begin
      if (stage_valid) wr_ptr <= wr_ptr + AW'(1);
      if (pop)         rd_ptr <= rd_ptr + AW'(1);

      case ({stage_valid, pop})
        2'b10:   committed <= committed + (AW+1)'(1);
        2'b01:   committed <= committed - (AW+1)'(1);
        default: committed <= committed;
      endcase

      case ({accept, pop})
        2'b10:   reserved <= reserved + (AW+1)'(1);
        2'b01:   reserved <= reserved - (AW+1)'(1);
        default: reserved <= reserved;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_q        <= '0;
      bus.out_valid <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      bus.out_valid <= pop || peek;
      bus.underflow <= pop_req && (committed == '0);
      if (pop)       word_q <= mem[rd_ptr];
      else if (peek) word_q <= mem[bus.read_pointer];
    end
  end

  assign bus.instruction_word = word_q;
  assign bus.count            = committed;
  assign bus.full             = (committed == (AW+1)'(DEPTH));
  assign bus.empty            = (committed == '0);

endmodule
